chess_clock_multi: RTL

CHESS_CLOCK_MULTI -- requirements
Module: chess_clock_multi

---
 rtl/chess_clock_multi_if.sv | 29 ++
 rtl/chess_clock_multi.sv | 124 ++++++++++++
 2 files changed

// File: rtl/chess_clock_multi_if.sv
// Control/status bundle for the multi-player chess clock: buttons and tick
// strobe in, per-player times and game status out.
interface chess_clock_multi_if #(
   parameter int PLAYERS = 2,
   parameter int TIME_W  = 16
);
   localparam int IDX_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

   logic                       i_tick;
   logic                       i_restart;
   logic                       i_stop;
   logic [PLAYERS-1:0]         i_turn;
   logic [PLAYERS*TIME_W-1:0]  o_time;
   logic [PLAYERS-1:0]         o_active;
   logic                       o_running;
   logic                       o_over;
   logic [IDX_W-1:0]           o_loser;
   logic                       o_restart;

   modport master (
      output i_tick, i_restart, i_stop, i_turn,
      input  o_time, o_active, o_running, o_over, o_loser, o_restart
   );

   modport slave (
      input  i_tick, i_restart, i_stop, i_turn,
      output o_time, o_active, o_running, o_over, o_loser, o_restart
   );
endinterface

// File: rtl/chess_clock_multi.sv
// Multi-player chess clock with Fischer increment: counts down the active
// player's time on each tick, rotates turns, pauses, and flags a loser at zero.
module chess_clock_multi #(
   parameter int PLAYERS   = 2,
   parameter int TIME_W    = 16,
   parameter int INIT_TIME = 300,
   parameter int INC       = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   chess_clock_multi_if.slave   bus
);
   localparam int IDX_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
   localparam logic [TIME_W-1:0] INIT_V   = TIME_W'(INIT_TIME);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PLAYERS - 1);

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_IDLE  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t             state;
   logic [TIME_W-1:0]  cnt_r [PLAYERS];
   logic [IDX_W-1:0]   active_idx;
   logic [IDX_W-1:0]   loser_idx;

   logic [TIME_W-1:0]  cur_cnt;
   logic [TIME_W-1:0]  dec_cnt;
   logic               cur_zero;
   logic               tick_dec;
   logic               restart_go;

   // Increment credited at turn end, clamped to the counter's full scale.
   function automatic logic [TIME_W-1:0] sat_add_inc(input logic [TIME_W-1:0] t);
      logic [TIME_W+31:0] sum;
      sum = {32'd0, t} + (TIME_W+32)'(INC);
      if (sum > {32'd0, {TIME_W{1'b1}}})
         return {TIME_W{1'b1}};
      return sum[TIME_W-1:0];
   endfunction

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [PLAYERS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = PLAYERS - 1; i >= 0; i--)
         if (v[i]) idx = IDX_W'(i);
      return idx;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] a);
      return (a == LAST_IDX) ? '0 : a + 1'b1;
   endfunction

   assign cur_cnt    = cnt_r[active_idx];
   assign cur_zero   = (cur_cnt == '0);
   assign tick_dec   = bus.i_tick && !cur_zero;
   assign dec_cnt    = cur_cnt - TIME_W'(tick_dec);
   assign restart_go = bus.i_restart && (state != S_START);

   // Restart overrides everything from any game state, so it shares the reset path.
   always_ff @(posedge i_clk) begin
      if (i_rst || restart_go) begin
         state      <= S_START;
         active_idx <= '0;
         loser_idx  <= '0;
         for (int p = 0; p < PLAYERS; p++)
            cnt_r[p] <= INIT_V;
      end else begin
         case (state)
            S_START: begin
               for (int p = 0; p < PLAYERS; p++)
                  cnt_r[p] <= INIT_V;
               state <= S_IDLE;
            end
            S_IDLE: begin
               if (|bus.i_turn) begin
                  active_idx <= lowest_idx(bus.i_turn);
                  state      <= S_RUN;
               end
            end
            S_RUN: begin
               cnt_r[active_idx] <= dec_cnt;
               if (bus.i_stop) begin
                  state <= S_PAUSE;
               end else if (cur_zero) begin
                  state     <= S_OVER;
                  loser_idx <= active_idx;
               end else if (bus.i_turn[active_idx]) begin
                  cnt_r[active_idx] <= sat_add_inc(dec_cnt);
                  active_idx        <= next_idx(active_idx);
               end
            end
            S_PAUSE: begin
               if (bus.i_turn[active_idx])
                  state <= S_RUN;
            end
            S_OVER: begin
               state <= S_OVER;
            end
            default: begin
               state <= S_START;
            end
         endcase
      end
   end

   for (genvar g = 0; g < PLAYERS; g++) begin : g_time
      assign bus.o_time[g*TIME_W +: TIME_W] = cnt_r[g];
   end

   always_comb begin
      bus.o_active = '0;
      if (state == S_RUN || state == S_PAUSE)
         bus.o_active[active_idx] = 1'b1;
   end

   assign bus.o_running = (state == S_RUN);
   assign bus.o_over    = (state == S_OVER);
   assign bus.o_restart = (state == S_START);
   assign bus.o_loser   = loser_idx;
endmodule
